// File: rtl/scan_seg_display.sv
// Purpose: N-digit BCD counter with a display latch and a time-multiplexed seven-segment scanner.
// Latency: Count is 1 cycle after Load/Enable, latch 1 after Count, and Seg/Digit_sel 1 after the latch. Backpressure: none, free-running scan.
// Optional LEADING_ZERO_BLANK_EN suppresses latched digits above the most significant nonzero digit.
module scan_seg_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  Enable,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Load_value,
    input  logic                  Hold,
    input  logic                  Blanking,
    output logic [4*DIGITS-1:0]   Count,
    output logic                  Carry_out,
    output logic [6:0]            Seg,
    output logic [DIGITS-1:0]     Digit_sel
);

    localparam int W     = 4 * DIGITS;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [W-1:0]     count_inc;
    logic [W-1:0]     latch;
    logic             all_nines;
    logic             ripple;
    logic [3:0]       inc_digit;
    logic [DIV_W-1:0] div_cnt;
    logic [IDX_W-1:0] idx;
    logic [3:0]       cur_digit;
    logic [6:0]       seg_nxt;
`ifdef LEADING_ZERO_BLANK_EN
    logic             upper_zero;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // Out-of-range nibbles (10-15) carry like a 9 and roll over to 0.
    always_comb begin
        count_inc = Count;
        ripple    = 1'b1;
        inc_digit = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            inc_digit = Count[4*k +: 4];
            if (ripple) begin
                count_inc[4*k +: 4] = (inc_digit >= 4'd9) ? 4'd0 : inc_digit + 4'd1;
            end
            ripple = ripple & (inc_digit >= 4'd9);
        end
        all_nines = ripple;
    end

    always_comb begin
        cur_digit = 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
        upper_zero = 1'b1;
`endif
        for (int k = 0; k < DIGITS; k++) begin
            if (IDX_W'(k) == idx) begin
                cur_digit = latch[4*k +: 4];
            end
`ifdef LEADING_ZERO_BLANK_EN
            if (IDX_W'(k) >= idx && latch[4*k +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
`endif
        end
        seg_nxt = seg_decode(cur_digit);
`ifdef LEADING_ZERO_BLANK_EN
        // Digit 0 is never suppressed so a zero count still shows one "0".
        if (idx != '0 && upper_zero) begin
            seg_nxt = 7'h00;
        end
`endif
        if (Blanking) begin
            seg_nxt = 7'h00;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Count     <= '0;
            Carry_out <= 1'b0;
            latch     <= '0;
        end else begin
            Carry_out <= Enable & ~Load & all_nines;
            if (Load) begin
                Count <= Load_value;
            end else if (Enable) begin
                Count <= count_inc;
            end
            if (!Hold) begin
                latch <= Count;
            end
        end
    end

    // Seg and Digit_sel both use the pre-edge index so they stay aligned.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            idx       <= '0;
            Seg       <= 7'h00;
            Digit_sel <= '0;
        end else begin
            Seg       <= seg_nxt;
            Digit_sel <= DIGITS'(1) << idx;
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scan_seg_display.sv
// Randomised and directed stimulus for scan_seg_display, scored against a decimal-arithmetic model.
module tb_scan_seg_display;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int W        = 4 * DIGITS;

    logic              clock = 1'b0;
    logic              reset;
    logic              Enable;
    logic              Load;
    logic [W-1:0]      Load_value;
    logic              Hold;
    logic              Blanking;
    logic [W-1:0]      Count;
    logic              Carry_out;
    logic [6:0]        Seg;
    logic [DIGITS-1:0] Digit_sel;

    scan_seg_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clock(clock), .reset(reset), .Enable(Enable), .Load(Load),
        .Load_value(Load_value), .Hold(Hold), .Blanking(Blanking),
        .Count(Count), .Carry_out(Carry_out), .Seg(Seg), .Digit_sel(Digit_sel)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0]      cnt;
        logic              carry;
        logic [6:0]        seg;
        logic [DIGITS-1:0] sel;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state: count and latch as plain decimal integers, time as cycles since reset.
    int m_cnt   = 0;
    int m_latch = 0;
    int m_t     = 0;

    logic [6:0] seg_lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int n);
        logic [W-1:0] r = '0;
        for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((n / pow10(k)) % 10);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("count",     32'(Count),     32'(mon_e.cnt));
            chk("carry_out", 32'(Carry_out), 32'(mon_e.carry));
            chk("seg",       32'(Seg),       32'(mon_e.seg));
            chk("digit_sel", 32'(Digit_sel), 32'(mon_e.sel));
        end
    end

    // Drive one edge of stimulus and queue what that edge must produce.
    task automatic cycle(input logic en, input logic ld, input int lval,
                         input logic hd, input logic bl);
        exp_t e;
        int   idx;
        Enable     = en;
        Load       = ld;
        Load_value = to_bcd(lval);
        Hold       = hd;
        Blanking   = bl;
        idx     = (m_t / SCAN_DIV) % DIGITS;
        e.sel   = DIGITS'(1) << idx;
        e.seg   = seg_lut[(m_latch / pow10(idx)) % 10];
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && m_latch < pow10(idx)) e.seg = 7'h00;
`endif
        if (bl) e.seg = 7'h00;
        e.carry = en && !ld && (m_cnt == pow10(DIGITS) - 1);
        if (!hd) m_latch = m_cnt;
        if (ld) m_cnt = lval;
        else if (en) m_cnt = (m_cnt + 1) % pow10(DIGITS);
        e.cnt = to_bcd(m_cnt);
        m_t++;
        exp_q.push_back(e);
        @(posedge clock);
        #2;
    endtask

    task automatic idle(input int n, input logic hd, input logic bl);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, hd, bl);
    endtask

    task automatic reset_mid;
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_seg",   32'(Seg),       32'h0);
        chk("rst_mid_sel",   32'(Digit_sel), 32'h0);
        chk("rst_mid_count", 32'(Count),     32'h0);
        chk("rst_mid_carry", 32'(Carry_out), 32'h0);
        exp_q.delete();
        m_cnt = 0; m_latch = 0; m_t = 0;
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; Enable = 1'b0; Load = 1'b0; Load_value = '0; Hold = 1'b0; Blanking = 1'b0;
        #3;
        chk("rst_seg",   32'(Seg),       32'h0);
        chk("rst_sel",   32'(Digit_sel), 32'h0);
        chk("rst_count", 32'(Count),     32'h0);
        chk("rst_carry", 32'(Carry_out), 32'h0);
        #9 reset = 1'b0;

        idle(6, 1'b0, 1'b0);
        // BCD carry through digit 1
        cycle(1'b0, 1'b1, 98, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
        idle(18, 1'b0, 1'b0);
        // Wrap, then Load+Enable at all-9s
        cycle(1'b0, 1'b1, 9999, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
        idle(3, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 9999, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 9999, 1'b0, 1'b0);
        idle(3, 1'b0, 1'b0);
        // Hold freezes the display while counting continues
        cycle(1'b0, 1'b1, 0, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 0, 1'b1, 1'b0);
        idle(16, 1'b1, 1'b0);
        idle(20, 1'b0, 1'b0);
        // Blanking
        idle(20, 1'b0, 1'b1);
        idle(4, 1'b0, 1'b0);
        // Leading-zero display
        cycle(1'b0, 1'b1, 42, 1'b0, 1'b0);
        idle(20, 1'b0, 1'b0);
        // Reset while digit 2 is being scanned
        for (int i = 0; i < DIGITS * SCAN_DIV && ((m_t / SCAN_DIV) % DIGITS) != 2; i++)
            idle(1, 1'b0, 1'b0);
        reset_mid();
        idle(12, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            int lv;
            lv = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 9999))
                                             : 9990 + int'($urandom_range(0, 9));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, lv,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end

        @(posedge clock);
        #3;
        chk("drain", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_seg_display.md
# scan_seg_display

Parametrised, time-multiplexed N-digit BCD counter and seven-segment driver. Holds a DIGITS-wide BCD count with load, enable, wrap carry and a display latch that can be frozen while counting continues. Drives one shared segment bus plus one-hot digit selects, scanning the latched digits in turn. Sits between the board-level count/control logic and the multiplexed LED display pins.

## Interface
- DIGITS, 4: number of BCD digits; legal range 1–8.
- SCAN_DIV, 4: clock cycles each digit stays selected; must be ≥1.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- Enable  in  1  increments the count by one on each clock edge where it is high.
- Load  in  1  loads Load_value into the count; has priority over Enable.
- Load_value  in  4*DIGITS  BCD load value; digit 0 occupies bits [3:0].
- Hold  in  1  freezes the display latch while high; the count is not frozen.
- Blanking  in  1  forces Seg to 0 while high; scanning continues.
- Count  out  4*DIGITS  current BCD count, registered.
- Carry_out  out  1  one-cycle pulse when the count wraps from all-9s to all-0s.
- Seg  out  7  active-high segments; Seg[0]=a through Seg[6]=g.
- Digit_sel  out  DIGITS  one-hot, active-high digit enable.

## Operation
- **Reset** (asynchronous): the following all clear to 0: Count, the display latch, the scan divider, the digit index, Seg, Digit_sel and Carry_out.
- **Count update** (per edge):
  - If Load is high, Count <= Load_value.
  - Else if Enable is high, Count <= Count + 1 in BCD.
  - Otherwise Count holds.
- **BCD increment:** digit 0 always increments. Digit k increments only if every lower digit is ≥9. A digit ≥9 that increments becomes 0. Nibbles 10–15 are therefore treated as 9 for carry purposes.
- **Carry_out:** is 1 for the cycle after an edge where Enable=1, Load=0 and every digit was ≥9; it is 0 otherwise.
- **Display latch:** on each edge, latch <= Count if Hold=0, otherwise latch holds.
- **Scanning:**
  - The divider counts 0..SCAN_DIV-1 and wraps.
  - When the divider equals SCAN_DIV-1, the index advances 0..DIGITS-1 and wraps.
  - One full frame is DIGITS*SCAN_DIV cycles.
- **Outputs** (both registered on each edge from the same pre-edge index, so they are always aligned):
  - Digit_sel <= one-hot(index).
  - Seg <= decode(latch digit[index]), or 0 if Blanking is high.
- **Decode table:**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66.
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 10–15 decode to 00.
- **Simultaneous Load and Enable:** Load wins and Carry_out stays 0.

## Timing
- Count latency: 1 cycle from Load/Enable.
- Display latch: 1 cycle after Count, provided Hold=0.
- Seg: updates 1 cycle after the latch.
- A count change is therefore visible on Seg 2 cycles later, at the next time that digit is selected.
- Blanking and Hold are sampled synchronously, with 1-cycle effect on Seg and on the latch respectively.
- Reset mid-operation clears all outputs immediately, without waiting for a clock edge.
- After reset is released, the first edge gives Digit_sel=one-hot(0) and Seg=7'h3F.

## Configuration
- Macro `LEADING_ZERO_BLANK_EN`.
- **Defined:** any latched digit above the most significant nonzero latched digit outputs Seg=0 while it is selected. Digit 0 is always displayed, so a zero count shows a single "0". The suppression decision uses the latch contents, in the same cycle as the decode.
- **Undefined:** every digit is decoded normally, so leading zeros display as 7'h3F.

## Test plan
All scenarios use the defaults, DIGITS=4 and SCAN_DIV=4.
- **Reset mid-frame:** assert reset asynchronously at index 2.
  - Seg, Digit_sel, Count and Carry_out all read 0 before the next edge.
  - After release, first edge gives Digit_sel=0001 and Seg=3F.
  - Digit_sel then changes every 4 cycles.
- **BCD carry:** Load 16'h0098, then Enable for 3 cycles.
  - Count sequence is 0099, 0100, 0101.
  - Carry_out stays 0 throughout.
  - Digit 1 slot shows 3F and digit 0 slot shows 06.
- **Wrap:** Load 16'h9999, then Enable for 1 cycle.
  - Count becomes 0000.
  - Carry_out is high for exactly 1 cycle.
  - Load+Enable together with 16'h9999 gives no pulse.
- **Hold:** with Hold=1, Enable for 5 cycles from 0000.
  - Count reaches 0005 while Seg for digit 0 stays 3F.
  - Drop Hold: the latch updates on the next edge and digit 0 shows 6D at its next slot.
- **Blanking:** raise Blanking for 20 cycles.
  - Seg is 0 throughout, starting 1 cycle after assertion.
  - Digit_sel keeps rotating 0001→0010→0100→1000 with a 16-cycle period.
- **Leading-zero option:** Load 16'h0042.
  - With `LEADING_ZERO_BLANK_EN`: slots 3 and 2 show 00, slot 1 shows 66, slot 0 shows 5B.
  - Without it: slots 3 and 2 show 3F.
